pipe_skid_buffer: RTL

//  Two-entry elastic pipeline stage with a valid/ready handshake on both sides.
//  The ready path is fully registered, so InReady has no combinational dependence on OutReady.

---
 rtl/pipe_skid_buffer_if.sv | 37 +++
 rtl/pipe_skid_buffer.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer_if.sv
// pipe_skid_buffer_if
// Handshake bundle for the two-entry skid buffer: upstream valid/ready/data
// and downstream valid/ready/data. The optional Flush line exists only when
// PIPE_SKID_FLUSH_EN is defined.
//   slave  : view of the buffer itself
//   master : view of the environment driving the buffer
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 8
) ();
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;
`ifdef PIPE_SKID_FLUSH_EN
    logic             Flush;

    modport slave (
        input  InValid, InData, OutReady, Flush,
        output InReady, OutValid, OutData
    );
    modport master (
        output InValid, InData, OutReady, Flush,
        input  InReady, OutValid, OutData
    );
`else
    modport slave (
        input  InValid, InData, OutReady,
        output InReady, OutValid, OutData
    );
    modport master (
        output InValid, InData, OutReady,
        input  InReady, OutValid, OutData
    );
`endif
endinterface

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
// Two-entry elastic stage (main + skid register) with valid/ready on both
// sides. InReady and OutValid come straight from flops, so there is no
// combinational path from OutReady back to InReady.
// Optional feature macro: PIPE_SKID_FLUSH_EN adds a synchronous Flush that
// empties the stage with priority over both handshakes.
module pipe_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e           state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             accept_s;
    logic             emit_s;

    assign accept_s     = bus.InValid & in_ready_r;
    assign emit_s       = out_valid_r & bus.OutReady;

    assign bus.InReady  = in_ready_r;
    assign bus.OutValid = out_valid_r;
    assign bus.OutData  = main_r;

    // State machine: moves entries between input, skid and main registers and
    // keeps OutValid/InReady registered in lockstep with the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_EMPTY;
            main_r      <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end
`ifdef PIPE_SKID_FLUSH_EN
        else if (bus.Flush) begin
            // Any beat handshaken this cycle is dropped; data regs keep stale values.
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end
`endif
        else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= bus.InData;
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && emit_s) begin
                        main_r      <= bus.InData;
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else if (accept_s) begin
                        // Downstream stalled: park the younger beat in skid.
                        skid_r      <= bus.InData;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end else if (emit_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        main_r      <= skid_r;
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule
